// File: rtl/led_fb_write_arbiter.sv
// Round-robin write-port arbiter for a double-buffered LED matrix framebuffer.
// Writers fill the back page (~display_page); a filled page is swapped in only
// on a scanner frame boundary so a partially drawn frame is never displayed.
module led_fb_write_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned X_RES   = 32,
  parameter int unsigned Y_RES   = 16,
  parameter int unsigned Y_SHIFT = 5,
  parameter int unsigned PIX_W   = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [8*NUM_REQ-1:0]    req_x,
  input  logic [8*NUM_REQ-1:0]    req_y,
  input  logic [24*NUM_REQ-1:0]   req_rgb,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic                    frame_done,
  output logic                    fb_we,
  output logic [PIX_W:0]          fb_addr,
  output logic [7:0]              fb_r,
  output logic [7:0]              fb_g,
  output logic [7:0]              fb_b,
  output logic                    display_page,
  output logic                    swap_pending,
  output logic [7:0]              drop_count
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned YW   = PIX_W - Y_SHIFT;

  typedef enum logic {StFill, StPending} page_st_e;

  page_st_e          state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]   gnt_idx;
  int unsigned       idx;
  logic              accept;
  logic [7:0]        sel_x;
  logic [7:0]        sel_y;
  logic [23:0]       sel_rgb;
  logic              sel_last;
  logic              in_range;
  logic [PIX_W-1:0]  pix_addr;

  // Rotating priority search: first valid requester at or above the pointer.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (grant == '0 && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = PtrW'(idx);
      end
    end
  end

  // Nothing is accepted while a finished back page waits for the swap, or in reset.
  assign req_ready    = (reset_n && !swap_pending) ? grant : '0;
  assign accept       = |(req_valid & req_ready);
  assign swap_pending = (state_q == StPending);

  // Beat fields of the granted requester; range check uses the full 8-bit coords.
  always_comb begin
    sel_x    = req_x[8*gnt_idx +: 8];
    sel_y    = req_y[8*gnt_idx +: 8];
    sel_rgb  = req_rgb[24*gnt_idx +: 24];
    sel_last = req_last[gnt_idx];
    in_range = (32'(sel_x) < X_RES) && (32'(sel_y) < Y_RES);
    pix_addr = PIX_W'((32'(sel_y[YW-1:0]) << Y_SHIFT) | 32'(sel_x[Y_SHIFT-1:0]));
  end

  // Pointer advances past the requester that was just served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= PtrW'((32'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  // Registered write port, one cycle after accept, always into the back page.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_r    <= '0;
      fb_g    <= '0;
      fb_b    <= '0;
    end else begin
      fb_we <= accept && in_range;
      if (accept && in_range) begin
        fb_addr <= {~display_page, pix_addr};
        fb_r    <= sel_rgb[23:16];
        fb_g    <= sel_rgb[15:8];
        fb_b    <= sel_rgb[7:0];
      end
    end
  end

  // Saturating count of beats accepted but discarded for out-of-range coordinates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (accept && !in_range && drop_count != 8'hff) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Page FSM: frame_done is only honoured once PENDING is already visible,
  // so the last write (one cycle after its accept) always precedes the swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFill;
      display_page <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept && sel_last) state_q <= StPending;
        end
        StPending: begin
          if (frame_done) begin
            state_q      <= StFill;
            display_page <= ~display_page;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_led_fb_write_arbiter.sv
// Directed bench for led_fb_write_arbiter: a cycle model derived from the
// arbitration/page rules is compared on every negedge, and hand-computed
// literals at key points pin the model.
module tb_led_fb_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [47:0] req_rgb;
  logic [1:0]  req_last;
  logic        frame_done;
  logic        fb_we;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_r;
  logic [7:0]  fb_g;
  logic [7:0]  fb_b;
  logic        display_page;
  logic        swap_pending;
  logic [7:0]  drop_count;

  int tests;
  int fails;
  bit chk_en;

  led_fb_write_arbiter #(
    .NUM_REQ(2), .X_RES(32), .Y_RES(16), .Y_SHIFT(5), .PIX_W(9)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rgb(req_rgb), .req_last(req_last),
    .frame_done(frame_done),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_r(fb_r), .fb_g(fb_g), .fb_b(fb_b),
    .display_page(display_page), .swap_pending(swap_pending), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  bit          m_pending;
  bit          m_page;
  int          m_drop;
  bit          m_we;
  int          m_addr;
  logic [23:0] m_rgb;

  int          m_grant;
  int          m_gi;
  int          m_idx;
  bit          m_acc;
  int          m_x;
  int          m_y;
  bit          m_last;
  bit          m_inr;
  logic [1:0]  exp_ready;

  always_comb begin
    m_grant = -1;
    m_idx   = 0;
    for (int k = 0; k < 2; k++) begin
      m_idx = (m_ptr + k) % 2;
      if (m_grant < 0 && req_valid[m_idx]) m_grant = m_idx;
    end
    m_acc     = reset_n && !m_pending && (m_grant >= 0);
    m_gi      = (m_grant < 0) ? 0 : m_grant;
    m_x       = int'(req_x[8*m_gi +: 8]);
    m_y       = int'(req_y[8*m_gi +: 8]);
    m_last    = req_last[m_gi];
    m_inr     = (m_x < 32) && (m_y < 16);
    exp_ready = m_acc ? ((m_gi == 0) ? 2'b01 : 2'b10) : 2'b00;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr <= 0; m_pending <= 0; m_page <= 0; m_drop <= 0; m_we <= 0; m_addr <= 0;
      m_rgb <= '0;
    end else begin
      m_we <= m_acc && m_inr;
      if (m_acc) begin
        m_ptr <= (m_gi + 1) % 2;
        if (m_inr) begin
          m_addr <= (m_page ? 0 : 512) + m_y * 32 + m_x;
          m_rgb  <= req_rgb[24*m_gi +: 24];
        end else if (m_drop < 255) begin
          m_drop <= m_drop + 1;
        end
      end
      if (m_pending && frame_done) begin
        m_pending <= 0;
        m_page    <= !m_page;
      end else if (!m_pending && m_acc && m_last) begin
        m_pending <= 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", 32'(req_ready), 32'(exp_ready));
      check("m_we", 32'(fb_we), 32'(m_we));
      if (m_we) begin
        check("m_addr", 32'(fb_addr), 32'(m_addr));
        check("m_rgb", {8'h0, fb_r, fb_g, fb_b}, {8'h0, m_rgb});
      end
      check("m_page", 32'(display_page), 32'(m_page));
      check("m_pending", 32'(swap_pending), 32'(m_pending));
      check("m_drop", 32'(drop_count), 32'(m_drop));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y,
                         input logic [23:0] rgb, input logic last);
    req_x[8*i +: 8]    = x;
    req_y[8*i +: 8]    = y;
    req_rgb[24*i +: 24] = rgb;
    req_last[i]        = last;
  endtask

  logic [1:0] g3 [4];
  int nwe;

  initial begin
    clk = 0; reset_n = 0; chk_en = 1; tests = 0; fails = 0; nwe = 0;
    req_valid = '0; req_x = '0; req_y = '0; req_rgb = '0; req_last = '0; frame_done = 0;
    g3 = '{2'b01, 2'b10, 2'b01, 2'b10};

    // 1: reset with toggling inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 2'($urandom); req_x = 16'($urandom); req_y = 16'($urandom);
      req_rgb = 48'($urandom); req_last = 2'($urandom); frame_done = 1'($urandom);
      @(negedge clk);
      check("rst_we", 32'(fb_we), 0);
      check("rst_addr", 32'(fb_addr), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_out", {fb_r, fb_g, fb_b, drop_count}, 0);
      check("rst_page", {30'h0, display_page, swap_pending}, 0);
    end
    tick();
    req_valid = '0; req_x = '0; req_y = '0; req_rgb = '0; req_last = '0; frame_done = 0;
    reset_n = 1;
    repeat (2) begin
      @(negedge clk);
      check("idle_we", 32'(fb_we), 0);
    end

    // 2: single write
    tick();
    set_req(0, 8'd3, 8'd2, 24'h112233, 1'b0);
    req_valid = 2'b01;
    @(negedge clk);
    check("t2_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t2_we", 32'(fb_we), 1);
    check("t2_addr", 32'(fb_addr), 32'h243);
    check("t2_rgb", {8'h0, fb_r, fb_g, fb_b}, 32'h112233);

    // 3: round robin from a fresh pointer
    tick(); reset_n = 0;
    tick(); reset_n = 1;
    tick();
    set_req(0, 8'd1, 8'd1, 24'hA0A0A0, 1'b0);
    set_req(1, 8'd2, 8'd3, 24'hB0B0B0, 1'b0);
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t3_grant", 32'(req_ready), 32'(g3[c]));
      if (c > 0) check("t3_we", 32'(fb_we), 1);
      if (c == 1) check("t3_addr0", 32'(fb_addr), 32'h221);
      if (c == 2) check("t3_addr1", 32'(fb_addr), 32'h262);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("t3_we4", 32'(fb_we), 1);
    tick();
    @(negedge clk);
    check("t3_we_end", 32'(fb_we), 0);

    // 4: last beat from req1, swap on a later frame_done
    tick();
    set_req(1, 8'd5, 8'd5, 24'hC0C0C0, 1'b1);
    req_valid = 2'b10;
    @(negedge clk);
    check("t4_ready", 32'(req_ready), 32'h2);
    tick();
    set_req(0, 8'd0, 8'd0, 24'h010203, 1'b0);
    set_req(1, 8'd5, 8'd5, 24'hC0C0C0, 1'b0);
    req_valid = 2'b11;
    @(negedge clk);
    check("t4_pending", 32'(swap_pending), 1);
    check("t4_blocked", 32'(req_ready), 0);
    check("t4_last_addr", 32'(fb_addr), 32'h2a5);
    repeat (3) tick();
    tick(); frame_done = 1;
    @(negedge clk);
    check("t4_still_pend", 32'(swap_pending), 1);
    tick(); frame_done = 0;
    @(negedge clk);
    check("t4_page", 32'(display_page), 1);
    check("t4_pend_clr", 32'(swap_pending), 0);
    check("t4_ready2", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    @(negedge clk);
    check("t4_we", 32'(fb_we), 1);
    check("t4_addr", 32'(fb_addr), 32'h000);

    // 5: frame_done coincident with last-accept is ignored
    tick();
    set_req(0, 8'd1, 8'd0, 24'h0A0B0C, 1'b1);
    req_valid = 2'b01; frame_done = 1;
    @(negedge clk);
    check("t5_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0; frame_done = 0; req_last = '0;
    @(negedge clk);
    check("t5_pending", 32'(swap_pending), 1);
    check("t5_noswap", 32'(display_page), 1);
    check("t5_addr", 32'(fb_addr), 32'h001);
    tick(); tick(); frame_done = 1;
    @(negedge clk);
    check("t5_wait", 32'(display_page), 1);
    tick(); frame_done = 0;
    @(negedge clk);
    check("t5_page", 32'(display_page), 0);
    check("t5_pend_clr", 32'(swap_pending), 0);

    // 6: out-of-range stream saturates drop_count, then async reset
    tick();
    set_req(0, 8'd40, 8'd1, 24'hFFFFFF, 1'b0);
    req_valid = 2'b01;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fb_we) nwe++;
      tick();
    end
    set_req(0, 8'd3, 8'd1, 24'h123456, 1'b0);
    @(negedge clk);
    check("t6_no_we", 32'(nwe + int'(fb_we)), 0);
    check("t6_sat", 32'(drop_count), 32'd255);
    tick(); req_valid = '0;
    @(negedge clk);
    check("t6_inflight_we", 32'(fb_we), 1);
    #2 reset_n = 0;
    #1;
    check("t6_async_drop", 32'(drop_count), 0);
    check("t6_async_we", 32'(fb_we), 0);
    tick(); reset_n = 1;
    @(negedge clk);
    check("t6_post_we", 32'(fb_we), 0);
    check("t6_post_drop", 32'(drop_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
